// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory request/ack and CPU instruction handoff.
interface fetch_queue_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        hlt;

    // Fetch queue side
    modport master (
        output mem_req, mem_addr, instr, instr_pc, instr_valid,
        input  mem_ack, mem_data, instr_ready, redirect, redirect_pc, hlt
    );

    // Memory / CPU side
    modport slave (
        input  mem_req, mem_addr, instr, instr_pc, instr_valid,
        output mem_ack, mem_data, instr_ready, redirect, redirect_pc, hlt
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding memory read at a time, a DEPTH-entry
// FIFO of {pc, instr}, flush on redirect, and a sticky halt that only rst clears.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;

    state_t        state_q, state_d;
    logic          pend_q, pend_d;     // request still outstanding while HALTED
    logic          first_q;            // first cycle after reset: ignore stale acks
    logic [15:0]   fetch_pc_q, fetch_pc_d;
    logic [15:0]   req_addr_q;         // address of the request in flight
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   ent_q [DEPTH];

    logic req, vld, ack_v, pop, push, flush, live;

    assign live  = (state_q != HALTED);
    assign ack_v = req && bus.mem_ack && !first_q;
    assign pop   = vld && bus.instr_ready;
    assign flush = live && (bus.hlt || bus.redirect);
    // Data of a request that was overtaken by a redirect/halt is never queued.
    assign push  = ack_v && (state_q == IDLE || state_q == WAIT) && !flush;

    // State register; reset abandons any request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            first_q <= 1'b0;
        end
    end

    // Next state: halt beats redirect, redirect beats normal fetch progress
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        fetch_pc_d = fetch_pc_q;
        if (state_q == HALTED) begin
            if (ack_v) pend_d = 1'b0;
        end else if (bus.hlt) begin
            state_d = HALTED;
            pend_d  = req && !ack_v;
        end else if (bus.redirect) begin
            state_d    = (req && !ack_v) ? DROP : IDLE;
            fetch_pc_d = {bus.redirect_pc[15:1], 1'b0};
        end else begin
            unique case (state_q)
                IDLE:      if (req && !ack_v) state_d = WAIT;
                WAIT, DROP: if (ack_v) state_d = IDLE;
                default:   state_d = state_q;
            endcase
            if (push) fetch_pc_d = fetch_pc_q + 16'd2;
        end
    end

    // Outputs: IDLE presents fetch_pc directly, later states replay the latched address
    always_comb begin
        req = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:       req = (count_q < CW'(DEPTH));
                WAIT, DROP: req = 1'b1;
                HALTED:     req = pend_q;
                default:    req = 1'b0;
            endcase
        end
        vld = !rst && live && (count_q != '0);
    end

    assign bus.mem_req     = req;
    assign bus.mem_addr    = rst ? 16'h0000 : ((state_q == IDLE) ? fetch_pc_q : req_addr_q);
    assign bus.instr_valid = vld;
    assign bus.instr       = vld ? ent_q[rd_q][15:0]  : 16'h0000;
    assign bus.instr_pc    = vld ? ent_q[rd_q][31:16] : 16'h0000;

    // Fetch PC, in-flight address and queue pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= 16'h0000;
            req_addr_q <= 16'h0000;
            rd_q       <= '0;
            wr_q       <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            if (state_q == IDLE && req) req_addr_q <= fetch_pc_q;
            if (flush) begin
                rd_q    <= '0;
                wr_q    <= '0;
                count_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage, no reset needed: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (push) ent_q[wr_q] <= {fetch_pc_q, bus.mem_data};
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Fetch queue bench: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (queue of entries + one outstanding request).
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_if bus();
    fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Reference model state
    logic [31:0] mq[$];            // queued {pc, instr}
    logic [15:0] m_pc;             // next fetch address
    bit          m_halt;
    bit          m_ov;             // a request was presented earlier and is unanswered
    logic [15:0] m_oaddr;
    bit          m_odrop;          // that request's data is to be thrown away
    bit          m_first;
    logic [31:0] log_q[$];         // DUT deliveries observed at handshakes

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h0000: return 16'hB102;
            16'h0002: return 16'hA100;
            16'h0004: return 16'hB201;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit r, input bit ack, input bit rdy, input bit redir,
                        input bit h, input logic [15:0] rpc, input bit rnd);
        bit e_req, e_vld, ackv;
        logic [15:0] e_addr;
        logic [31:0] head;
        @(negedge clk);
        rst             = r;
        bus.mem_ack     = ack;
        bus.mem_data    = rnd ? 16'($urandom) : mem_fn(m_ov ? m_oaddr : m_pc);
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.hlt         = h;
        #1;
        head = (mq.size() != 0) ? mq[0] : 32'h0;
        if (r) begin
            e_req = 0; e_addr = 16'h0; e_vld = 0;
        end else begin
            e_req  = m_halt ? m_ov : (m_ov || mq.size() < DEPTH);
            e_addr = m_ov ? m_oaddr : m_pc;
            e_vld  = !m_halt && mq.size() != 0;
        end
        chk("mem_req", 32'(bus.mem_req), 32'(e_req));
        if (r || !m_halt || m_ov) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("instr_valid", 32'(bus.instr_valid), 32'(e_vld));
        chk("instr", 32'(bus.instr), e_vld ? 32'(head[15:0]) : 32'h0);
        chk("instr_pc", 32'(bus.instr_pc), e_vld ? 32'(head[31:16]) : 32'h0);
        if (bus.instr_valid && rdy) log_q.push_back({bus.instr_pc, bus.instr});

        if (r) begin
            mq.delete(); m_pc = 16'h0; m_halt = 0; m_ov = 0; m_odrop = 0; m_first = 1;
            return;
        end
        ackv    = e_req && ack && !m_first;
        m_first = 0;
        if (e_vld && rdy) void'(mq.pop_front());
        if (m_halt) begin
            if (ackv) m_ov = 0;
        end else if (h) begin
            m_halt = 1; mq.delete();
            m_ov = e_req && !ackv; m_oaddr = e_addr;
        end else if (redir) begin
            mq.delete();
            m_ov = e_req && !ackv; m_oaddr = e_addr; m_odrop = m_ov;
            m_pc = rpc & 16'hFFFE;
        end else if (ackv) begin
            if (!m_odrop) begin
                mq.push_back({m_pc, bus.mem_data});
                m_pc = m_pc + 16'd2;
            end
            m_ov = 0; m_odrop = 0;
        end else if (e_req && !m_ov) begin
            m_ov = 1; m_oaddr = e_addr; m_odrop = 0;
        end
    endtask

    task automatic go(input bit ack, input bit rdy);
        step(0, ack, rdy, 0, 0, 16'h0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 16'h0, 0);
        step(1, 1, 0, 0, 0, 16'h0, 0);
        log_q.delete();
    endtask

    initial begin
        bus.mem_ack = 0; bus.mem_data = '0; bus.instr_ready = 0;
        bus.redirect = 0; bus.redirect_pc = '0; bus.hlt = 0;

        // Streaming with acks every cycle
        do_reset();
        repeat (10) go(1, 1);
        chk("stream_n", 32'(log_q.size() >= 3), 32'd1);
        if (log_q.size() >= 3) begin
            chk("stream0", log_q[0], 32'h0000_B102);
            chk("stream1", log_q[1], 32'h0002_A100);
            chk("stream2", log_q[2], 32'h0004_B201);
        end

        // Fill to DEPTH with no consumer, then one pop re-opens requests
        do_reset();
        repeat (12) go(1, 0);
        chk("full_req", 32'(bus.mem_req), 32'd0);
        chk("full_addr", 32'(bus.mem_addr), 32'h0008);
        go(0, 1);
        go(0, 0);
        chk("refill_req", 32'(bus.mem_req), 32'd1);

        // Redirect while the request for 0x0006 is pending
        do_reset();
        go(0, 0);
        repeat (3) go(1, 0);
        go(0, 0);
        step(0, 0, 0, 1, 0, 16'h0005, 0);
        go(1, 0);
        go(0, 0);
        chk("redir_addr", 32'(bus.mem_addr), 32'h0004);
        chk("redir_empty", 32'(bus.instr_valid), 32'd0);
        go(1, 0);
        go(0, 0);
        chk("redir_instr", {bus.instr_pc, bus.instr}, 32'h0004_B201);

        // Redirect, ack and pop in the same cycle
        do_reset();
        go(0, 0);
        go(1, 0);
        step(0, 1, 1, 1, 0, 16'h0100, 0);
        go(0, 0);
        chk("sim_popped", 32'(log_q.size()), 32'd1);
        chk("sim_addr", 32'(bus.mem_addr), 32'h0100);
        chk("sim_empty", 32'(bus.instr_valid), 32'd0);

        // Halt with three entries and a request outstanding
        do_reset();
        go(0, 0);
        repeat (3) go(1, 0);
        go(0, 0);
        step(0, 0, 1, 0, 1, 16'h0, 0);
        chk("hlt_valid", 32'(bus.instr_valid), 32'd1);
        go(0, 1);
        chk("hlt_drained", 32'(bus.instr_valid), 32'd0);
        chk("hlt_pend", 32'(bus.mem_req), 32'd1);
        go(1, 1);
        step(0, 1, 1, 1, 0, 16'h0040, 0);
        repeat (4) go(1, 1);
        chk("hlt_noreq", 32'(bus.mem_req), 32'd0);

        // Fetch PC wrap, then reset in the middle of a request
        do_reset();
        step(0, 0, 1, 1, 0, 16'hFFFF, 0);
        repeat (6) go(1, 1);
        chk("wrap_n", 32'(log_q.size() >= 2), 32'd1);
        if (log_q.size() >= 2) begin
            chk("wrap_pc0", 32'(log_q[0][31:16]), 32'h0000FFFE);
            chk("wrap_pc1", 32'(log_q[1][31:16]), 32'h00000000);
        end
        go(0, 0);
        step(1, 0, 0, 0, 0, 16'h0, 0);
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'h0);
        go(1, 0);
        chk("post_rst_req", 32'(bus.mem_req), 32'd1);
        chk("post_rst_addr", 32'(bus.mem_addr), 32'h0);
        go(0, 0);
        chk("stale_ack", 32'(bus.instr_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (16'hFFF8 | 16'($urandom_range(0, 7)))
                                              : 16'($urandom);
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 199) < 1, rpc, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the instruction queue entry count (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have port mem_req, output, 1, meaning the instruction-memory read request.
REQ-005 The block SHALL have port mem_addr, output, 16, meaning the byte address of the requested instruction.
REQ-006 The block SHALL have port mem_ack, input, 1, meaning mem_data is valid this cycle and completes the request.
REQ-007 The block SHALL have port mem_data, input, 16, meaning the instruction word returned.
REQ-008 The block SHALL have port instr, output, 16, meaning the head-of-queue instruction delivered to the CPU instr_in.
REQ-009 The block SHALL have port instr_pc, output, 16, meaning the fetch address of instr.
REQ-010 The block SHALL have port instr_valid, output, 1, meaning instr/instr_pc are valid.
REQ-011 The block SHALL have port instr_ready, input, 1, meaning the CPU accepts instr this cycle.
REQ-012 The block SHALL have port redirect, input, 1, meaning a taken branch/BR/PCS-type PC change.
REQ-013 The block SHALL have port redirect_pc, input, 16, meaning the new fetch address.
REQ-014 The block SHALL have port hlt, input, 1, meaning the CPU decoded HLT (0xFxxx).

Function
REQ-015 The block SHALL keep fetch_pc, byte-addressed, incremented by 2 per accepted mem_ack, wrapping 0xFFFE -> 0x0000.
REQ-016 The block SHALL implement FSM states IDLE, WAIT, DROP, HALTED.
REQ-017 IDLE: the block SHALL assert mem_req with mem_addr=fetch_pc whenever count < DEPTH, moving to WAIT the same cycle.
REQ-018 WAIT: the block SHALL hold mem_req high and mem_addr stable until mem_ack, allowing at most one outstanding request.
REQ-019 On mem_ack in WAIT, the block SHALL push {fetch_pc, mem_data}, advance fetch_pc, and return to IDLE.
REQ-020 Handshake: an entry SHALL be consumed only when instr_valid and instr_ready are both high in the same cycle.
REQ-021 instr_valid SHALL equal (count != 0) and not HALTED.
REQ-022 When instr_valid is low, the block SHALL drive instr=0x0000 and instr_pc=0x0000.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged; count SHALL never exceed DEPTH or underflow.
REQ-024 Redirect SHALL flush the queue (count=0 next cycle) and load fetch_pc=redirect_pc with bit 0 forced to 0.
REQ-025 Redirect in WAIT without mem_ack SHALL go to DROP.
REQ-026 DROP SHALL hold mem_req until mem_ack, discard that data, and then go to IDLE.
REQ-027 Redirect coincident with mem_ack SHALL discard the data and go to IDLE with the new fetch_pc.
REQ-028 Redirect coincident with a pop SHALL complete the pop and apply the flush.
REQ-029 hlt SHALL flush the queue and enter HALTED.
REQ-030 In HALTED, the block SHALL issue no new request, keep instr_valid low, and finish any outstanding request with its data discarded.
REQ-031 HALTED SHALL be exited only by rst.
REQ-032 hlt and redirect in the same cycle SHALL be resolved with hlt taking priority.
REQ-033 Fill latency SHALL be one cycle: an entry pushed on an ack edge appears on instr with instr_valid high in the following cycle.

Reset
REQ-034 While rst is high, the block SHALL set state=IDLE, fetch_pc=0x0000, count=0, mem_req=0, mem_addr=0x0000, instr_valid=0, instr=0x0000, instr_pc=0x0000.
REQ-035 rst mid-request SHALL abandon the outstanding request without waiting for mem_ack; a stale mem_ack in the first cycle after reset SHALL be ignored.
REQ-036 The first request SHALL issue in the first cycle after rst deasserts, with mem_addr=0x0000.

Verification
REQ-037 Streaming: memory acks every cycle with 0xB102, 0xA100, 0xB201; instr_ready=1 -> instr sequence 0xB102@0x0000, 0xA100@0x0002, 0xB201@0x0004, no gaps after first.
REQ-038 Full: instr_ready=0, immediate acks -> exactly DEPTH=4 entries, then mem_req low with mem_addr=0x0008; mem_req re-asserts the cycle after the first pop.
REQ-039 Redirect in WAIT: redirect_pc=0x0005 while the request for 0x0006 is pending -> ack data discarded, next mem_addr=0x0004, queue empty until the 0x0004 data arrives.
REQ-040 Simultaneous: redirect, mem_ack, and pop in one cycle -> popped entry consumed once, ack data absent from queue, next request to redirect_pc.
REQ-041 Halt: hlt with 3 entries queued and a request outstanding -> instr_valid=0 next cycle, no further mem_req after the outstanding ack, state held until rst.
REQ-042 Wrap and reset: fetch_pc=0xFFFE acked -> next mem_addr=0x0000; rst asserted mid-WAIT -> all outputs per REQ-034 the next cycle.
